// File: rtl/barrel_shift_stage.sv
// rtl/barrel_shift_stage.sv - registered, flow-controlled 8-bit logical-left barrel shift stage
//
// barrel_shifter8 : combinational 8-bit logical-left shifter
//   data [7:0] in, shift [2:0] in, result [7:0] out
//
// barrel_shift_stage : S1 register + shifter + 2-entry output FIFO + overflow counter
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   in_valid       in   upstream transfer pending
//   in_ready       out  stage can accept (never depends on out_ready)
//   in_data  [7:0] in   operand
//   in_shift [2:0] in   left-shift magnitude
//   out_valid      out  FIFO head valid
//   out_ready      in   downstream accepts the head
//   out_data [7:0] out  shifted operand, truncated to 8 bits
//   out_spill[7:0] out  bits shifted out, right-aligned
//   out_ovf        out  any spill bit set
//   ovf_count[15:0]out  saturating count of popped results with out_ovf=1
//   cnt_clr        in   synchronous clear of ovf_count

module barrel_shifter8 (
  input  logic [7:0] data,
  input  logic [2:0] shift,
  output logic [7:0] result
);

  logic [7:0] st1;
  logic [7:0] st2;

  assign st1    = shift[0] ? {data[6:0], 1'b0}  : data;
  assign st2    = shift[1] ? {st1[5:0], 2'b00}  : st1;
  assign result = shift[2] ? {st2[3:0], 4'h0}   : st2;

endmodule

module barrel_shift_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic [2:0]  in_shift,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [7:0]  out_spill,
  output logic        out_ovf,
  output logic [15:0] ovf_count,
  input  logic        cnt_clr
);

  logic        s1_v;
  logic [7:0]  s1_data;
  logic [2:0]  s1_shift;
  logic [7:0]  s1_res;
  logic [7:0]  s1_spill;
  logic        s1_ovf;

  // FIFO entry layout: {ovf, spill[7:0], data[7:0]}
  logic [16:0] fifo_mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  fifo_cnt;
  logic [16:0] head;

  logic        accept;
  logic        move;
  logic        pop;

  barrel_shifter8 u_shifter (
    .data   (s1_data),
    .shift  (s1_shift),
    .result (s1_res)
  );

  // Spill is the top bits of the operand that fall off the left edge.
  // A shift of 0 turns into a right shift by 8, which yields zero.
  assign s1_spill = s1_data >> (4'd8 - {1'b0, s1_shift});
  assign s1_ovf   = |s1_spill;

  // Move is decided on the pre-pop count, so a full FIFO blocks the move
  // even when a pop happens on the same edge; in_ready therefore never
  // needs to look at out_ready.
  assign move     = s1_v && (fifo_cnt != 2'd2);
  assign in_ready = !rst && !(s1_v && (fifo_cnt == 2'd2));
  assign accept   = in_valid && in_ready;

  assign head      = fifo_mem[rd_ptr];
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = out_valid ? head[7:0]  : 8'h00;
  assign out_spill = out_valid ? head[15:8] : 8'h00;
  assign out_ovf   = out_valid ? head[16]   : 1'b0;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_data  <= 8'h00;
      s1_shift <= 3'd0;
    end else if (accept) begin
      s1_v     <= 1'b1;
      s1_data  <= in_data;
      s1_shift <= in_shift;
    end else if (move) begin
      s1_v     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_mem[0] <= 17'h0;
      fifo_mem[1] <= 17'h0;
    end else begin
      if (move) begin
        fifo_mem[wr_ptr] <= {s1_ovf, s1_spill, s1_res};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({move, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      ovf_count <= 16'h0000;
    end else if (pop && head[16] && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end

endmodule
